// File: rtl/ldpc_dec_payload_extract.sv
// Hard-decision payload extractor: keeps systematic words of each codeword frame,
// checks frame geometry and replays the payload from a two-bank ping-pong store.
module ldpc_dec_payload_extract #(
  parameter int pDAT_W   = 8,
  parameter int pTAG_W   = 4,
  parameter int pPAY_NUM = 6,
  parameter int pFRM_NUM = 12
)(
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              iclkena,
  input  logic              isop,
  input  logic              ieop,
  input  logic              ieof,
  input  logic              ival,
  input  logic [pTAG_W-1:0] itag,
  input  logic [pDAT_W-1:0] idat,
  output logic              ordy,
  input  logic              iordy,
  output logic              osop,
  output logic              oeop,
  output logic              oval,
  output logic [pTAG_W-1:0] otag,
  output logic [pDAT_W-1:0] odat,
  output logic              oerr
);
  localparam int CW = $clog2(pFRM_NUM + 1);
  localparam int IW = (pPAY_NUM > 1) ? $clog2(pPAY_NUM) : 1;
  localparam logic [CW-1:0] cPAY  = CW'(pPAY_NUM);
  localparam logic [CW-1:0] cFRM  = CW'(pFRM_NUM);
  localparam logic [IW-1:0] cLAST = IW'(pPAY_NUM - 1);

  typedef enum logic [1:0] {cWAIT_SOP, cPAYLOAD, cPARITY} wst_t;
  typedef enum logic       {cIDLE, cSEND}                 rst_t;

  logic [1:0][pPAY_NUM-1:0][pDAT_W-1:0] r_mem;
  logic [1:0][pTAG_W-1:0]               r_btag;
  logic [1:0]                           r_berr, r_full;
  logic                                 r_wb, r_rb;
  wst_t                                 r_wst, w_st;
  rst_t                                 r_rst;
  logic [CW-1:0]                        r_pcnt, r_fcnt, w_pc, w_fc;
  logic                                 r_err, w_err;
  logic [IW-1:0]                        r_ridx, w_widx;
  logic                                 w_acc, w_wr, w_commit, w_ld, w_go, w_last;
  logic [1:0]                           w_cmt, w_free;
  logic [pDAT_W-1:0]                    r_odat;
  logic [pTAG_W-1:0]                    r_otag;
  logic                                 r_osop, r_oeop, r_oval, r_oerr;

  assign ordy  = !r_full[r_wb];
  assign w_acc = iclkena & ival & ordy;

  // Next write-side state for the accepted word; isop restarts in the same bank.
  always_comb begin
    w_st = r_wst; w_pc = r_pcnt; w_fc = r_fcnt; w_err = r_err;
    w_wr = 1'b0; w_commit = 1'b0; w_widx = '0;
    if (w_acc) begin
      if (isop) begin
        w_st = cPAYLOAD; w_pc = '0; w_fc = '0; w_err = 1'b0;
      end
      if (w_st != cWAIT_SOP) begin
        // A saturated frame counter means the frame overran its length.
        if (w_fc == cFRM) w_err = 1'b1;
        else              w_fc  = w_fc + 1'b1;
        if (w_st == cPAYLOAD) begin
          if (w_pc < cPAY) begin
            w_wr = 1'b1; w_widx = w_pc[IW-1:0];
          end else
            w_err = 1'b1;
          if (w_pc != cFRM) w_pc = w_pc + 1'b1;
          if (ieop) begin
            if (w_pc != cPAY) w_err = 1'b1;
            w_st = cPARITY;
          end else if (ieof)
            w_err = 1'b1;
        end
        if (ieof) begin
          if (w_fc != cFRM) w_err = 1'b1;
          w_commit = 1'b1;
          w_st     = cWAIT_SOP;
        end
      end
    end
  end

  always_ff @(posedge iclk or negedge ireset_n)
    if (!ireset_n) begin
      r_wst  <= cWAIT_SOP;
      r_pcnt <= '0;
      r_fcnt <= '0;
      r_err  <= 1'b0;
      r_wb   <= 1'b0;
      r_mem  <= '0;
      r_btag <= '0;
      r_berr <= '0;
    end else if (iclkena) begin
      r_wst  <= w_st;
      r_pcnt <= w_pc;
      r_fcnt <= w_fc;
      r_err  <= w_err;
      // Clearing on sop makes undelivered payload words read back as zero.
      if (w_acc & isop) begin
        r_mem[r_wb]  <= '0;
        r_btag[r_wb] <= itag;
      end
      if (w_wr) r_mem[r_wb][w_widx] <= idat;
      if (w_commit) begin
        r_berr[r_wb] <= w_err;
        r_wb         <= ~r_wb;
      end
    end

  assign w_ld   = !r_oval | iordy;
  assign w_go   = (r_rst == cSEND) | r_full[r_rb];
  assign w_last = (r_ridx == cLAST);
  assign w_cmt  = w_commit ? (r_wb ? 2'b10 : 2'b01) : 2'b00;
  // The bank is released once its last word is copied into the output register.
  assign w_free = (w_ld & w_go & w_last) ? (r_rb ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge iclk or negedge ireset_n)
    if (!ireset_n) begin
      r_full <= '0;
      r_rb   <= 1'b0;
      r_rst  <= cIDLE;
      r_ridx <= '0;
      r_oval <= 1'b0;
      r_osop <= 1'b0;
      r_oeop <= 1'b0;
      r_odat <= '0;
      r_otag <= '0;
      r_oerr <= 1'b0;
    end else if (iclkena) begin
      r_full <= (r_full & ~w_free) | w_cmt;
      if (w_ld) begin
        if (w_go) begin
          r_oval <= 1'b1;
          r_odat <= r_mem[r_rb][r_ridx];
          r_osop <= (r_ridx == '0);
          r_oeop <= w_last;
          r_otag <= r_btag[r_rb];
          r_oerr <= r_berr[r_rb];
          if (w_last) begin
            r_rb   <= ~r_rb;
            r_ridx <= '0;
            r_rst  <= r_full[~r_rb] ? cSEND : cIDLE;
          end else begin
            r_ridx <= r_ridx + 1'b1;
            r_rst  <= cSEND;
          end
        end else begin
          r_oval <= 1'b0;
          r_osop <= 1'b0;
          r_oeop <= 1'b0;
        end
      end
    end

  assign oval = r_oval;
  assign osop = r_osop;
  assign oeop = r_oeop;
  assign odat = r_odat;
  assign otag = r_otag;
  assign oerr = r_oerr;
endmodule

// File: tb/tb_ldpc_dec_payload_extract.sv
// Scoreboard bench for ldpc_dec_payload_extract: frames in, expected payload queued, popped at output.
module tb_ldpc_dec_payload_extract;
  logic       iclk = 1'b0, ireset_n, iclkena, isop, ieop, ieof, ival, iordy;
  logic [3:0] itag, otag;
  logic [7:0] idat, odat;
  logic       ordy, osop, oeop, oval, oerr;

  typedef struct packed {
    logic [7:0] dat;
    logic       sop, eop, err;
    logic [3:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0, n_sop = 0;

  ldpc_dec_payload_extract #(.pDAT_W(8), .pTAG_W(4), .pPAY_NUM(6), .pFRM_NUM(12)) dut (
    .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena), .isop(isop), .ieop(ieop),
    .ieof(ieof), .ival(ival), .itag(itag), .idat(idat), .ordy(ordy), .iordy(iordy),
    .osop(osop), .oeop(oeop), .oval(oval), .otag(otag), .odat(odat), .oerr(oerr));

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one frame (sop on word 1, eop on word eop_pos, eof on word nw if eof_en)
  // and queues the payload the consumer should see.
  task automatic send_frame(input logic [3:0] tag, input int nw, input int eop_pos,
                            input int base, input bit eof_en, input bit push);
    int np;
    bit err;
    int tmo;
    np  = (eop_pos > 0) ? eop_pos : nw;
    err = (eop_pos != 6) || (nw != 12);
    if (push)
      for (int i = 0; i < 6; i++) begin
        exp_t e;
        e.dat = (i < np) ? 8'(base + i + 1) : 8'd0;
        e.sop = (i == 0);
        e.eop = (i == 5);
        e.err = err;
        e.tag = tag;
        sb.push_back(e);
      end
    for (int k = 1; k <= nw; k++) begin
      ival = 1'b1;
      isop = (k == 1);
      ieop = (k == eop_pos);
      ieof = eof_en && (k == nw);
      itag = (k == 1) ? tag : 4'hx;
      idat = 8'(base + k);
      tmo  = 0;
      forever begin
        @(negedge iclk);
        if (ordy) break;
        if (++tmo > 2000) begin
          chk("ordy_timeout", 0, 1);
          break;
        end
      end
      @(posedge iclk); #1;
    end
    ival = 1'b0; isop = 1'b0; ieop = 1'b0; ieof = 1'b0;
  endtask

  task automatic drain();
    int tmo;
    tmo = 0;
    while (sb.size() != 0 && tmo < 500) begin
      @(posedge iclk); #1;
      tmo++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  always @(negedge iclk)
    if (ireset_n && oval) begin
      if (iordy) begin
        if (sb.size() == 0) chk("extra_word", {24'd0, odat}, 32'hffff_ffff);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("dat", odat, e.dat);
          chk("ctl", {osop, oeop, oerr, otag}, {e.sop, e.eop, e.err, e.tag});
          if (osop) n_sop++;
        end
      end else if (sb.size() != 0)
        chk("hold", {osop, oeop, oerr, otag, odat}, {sb[0].sop, sb[0].eop, sb[0].err, sb[0].tag, sb[0].dat});
    end

  initial begin
    int s0;
    ireset_n = 1'b0; iclkena = 1'b1; iordy = 1'b1;
    ival = 1'b0; isop = 1'b0; ieop = 1'b0; ieof = 1'b0; itag = '0; idat = '0;
    @(negedge iclk);
    chk("rst_oval", oval, 0);
    chk("rst_flags", {osop, oeop, oerr}, 3'b000);
    chk("rst_odat", odat, 0);
    chk("rst_otag", otag, 0);
    chk("rst_ordy", ordy, 1);
    @(posedge iclk); #1 ireset_n = 1'b1;

    // Nominal frame and first-word latency
    send_frame(4'd5, 12, 6, 0, 1, 1);
    @(negedge iclk); chk("lat_e0", oval, 0);
    @(negedge iclk); chk("lat_e1", {oval, osop, odat}, {1'b1, 1'b1, 8'd1});
    drain();

    // Ping-pong with a stalled consumer
    iordy = 1'b0;
    fork
      for (int f = 0; f < 4; f++) send_frame(4'(f + 1), 12, 6, 16 * f + 20, 1, 1);
    join_none
    repeat (40) @(posedge iclk);
    @(negedge iclk); chk("pp_both_full", ordy, 0);
    @(posedge iclk); #1 iordy = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge iclk);
      chk("pp_contig", oval, 1);
      if (k == 5) chk("pp_ordy_low", ordy, 0);
      if (k == 7) chk("pp_ordy_rise", ordy, 1);
    end
    wait fork;
    drain();

    // Geometry errors
    send_frame(4'd3, 12, 4, 40, 1, 1);
    send_frame(4'd4, 14, 6, 60, 1, 1);
    send_frame(4'd6, 12, 0, 80, 1, 1);
    send_frame(4'd7, 1, 1, 90, 1, 1);
    drain();

    // Restart mid-frame: only the good frame comes out
    s0 = n_sop;
    send_frame(4'd2, 3, 0, 100, 0, 0);
    send_frame(4'd9, 12, 6, 110, 1, 1);
    drain();
    chk("restart_frames", n_sop - s0, 1);

    // Random backpressure
    fork
      for (int f = 0; f < 3; f++) send_frame(4'(f + 10), 12, 6, 30 * f + 5, 1, 1);
      repeat (150) begin
        @(posedge iclk); #1 iordy = 1'($urandom_range(0, 1));
      end
    join
    iordy = 1'b1;
    drain();

    // Reset while a frame sits at the output
    iordy = 1'b0;
    send_frame(4'd8, 12, 6, 200, 1, 1);
    repeat (3) @(posedge iclk);
    #2 ireset_n = 1'b0;
    #1;
    chk("rst_mid_oval", oval, 0);
    chk("rst_mid_ordy", ordy, 1);
    sb.delete();
    @(posedge iclk); #1 ireset_n = 1'b1; iordy = 1'b1;
    send_frame(4'd1, 12, 6, 150, 1, 1);
    drain();

    repeat (5) @(posedge iclk);
    chk("final_idle", oval, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
